// File: rtl/agc_gain_ctrl_pkg.sv
// Shared types, settings-bus offsets and reset values for the ATSC RX AGC gain controller.
package agc_gain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    HOLD    = 2'd3
  } agc_state_e;

  localparam int MAG_W = 17;

  localparam int unsigned SR_CTRL      = 0;
  localparam int unsigned SR_TARGET    = 1;
  localparam int unsigned SR_HYST      = 2;
  localparam int unsigned SR_STEP      = 3;
  localparam int unsigned SR_HOLD      = 4;
  localparam int unsigned SR_INIT_GAIN = 5;

  localparam logic        ENABLE_RST = 1'b0;
  localparam logic [16:0] TARGET_RST = 17'h04000;
  localparam logic [15:0] HYST_RST   = 16'h0400;
  localparam logic [15:0] STEP_RST   = 16'h0100;
  localparam logic [15:0] HOLD_RST   = 16'd16;
  localparam logic [15:0] GAIN_UNITY = 16'h1000;

  // Exact |v| of a signed sc16 component; |-32768| needs the 17th bit.
  function automatic logic [MAG_W-1:0] abs_sc16(input logic [15:0] v);
    return v[15] ? (~{1'b1, v}) + 17'd1 : {1'b0, v};
  endfunction

endpackage

// File: rtl/agc_mag_accum.sv
// Sums |I|+|Q| over a 2^WIN_LOG2-sample window and flags the sample that completes it.
module agc_mag_accum
  import agc_gain_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic             sample_fire,
  input  logic [31:0]      sample,
  output logic [MAG_W-1:0] avg,
  output logic             win_done
);

  localparam int ACC_W = MAG_W + WIN_LOG2;

  logic [MAG_W-1:0]    mag;
  logic [ACC_W-1:0]    acc;
  logic [WIN_LOG2-1:0] count;
  logic                take;

  assign mag      = abs_sc16(sample[31:16]) + abs_sc16(sample[15:0]);
  assign take     = count_en & sample_fire & ~clear;
  assign win_done = take & (count == '1);
  assign avg      = acc[ACC_W-1:WIN_LOG2];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else if (take) begin
      acc   <= acc + ACC_W'(mag);
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/agc_gain_ctrl.sv
// Closed-loop AGC gain controller: windowed mean magnitude vs. target with hysteresis,
// stepped gain with settling hold, configured over the noc_shell settings bus.
module agc_gain_ctrl
  import agc_gain_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int GAIN_W   = 16,
  parameter int SR_BASE  = 130
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [31:0]       mon_tdata,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  output logic [GAIN_W-1:0] gain,
  output logic              gain_valid,
  output logic              locked,
  output logic [16:0]       avg_mag
);

  localparam int ARITH_W = (GAIN_W > 16 ? GAIN_W : 16) + 1;
  localparam logic [ARITH_W-1:0] GAIN_MAX = ARITH_W'({GAIN_W{1'b1}});

  agc_state_e state, state_next;

  logic        enable;
  logic [16:0] target;
  logic [15:0] hyst;
  logic [15:0] step;
  logic [15:0] hold_cycles;
  logic [15:0] hold_cnt;

  logic wr_ctrl, wr_target, wr_hyst, wr_step, wr_hold, wr_init;
  logic acc_clear, acc_en, decide_en, win_done;
  logic [MAG_W-1:0] avg;
  logic unused_set_bits;

  assign wr_ctrl   = set_stb && (set_addr == 8'(SR_BASE + SR_CTRL));
  assign wr_target = set_stb && (set_addr == 8'(SR_BASE + SR_TARGET));
  assign wr_hyst   = set_stb && (set_addr == 8'(SR_BASE + SR_HYST));
  assign wr_step   = set_stb && (set_addr == 8'(SR_BASE + SR_STEP));
  assign wr_hold   = set_stb && (set_addr == 8'(SR_BASE + SR_HOLD));
  assign wr_init   = set_stb && (set_addr == 8'(SR_BASE + SR_INIT_GAIN));
  assign unused_set_bits = ^set_data[31:17];

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      enable      <= ENABLE_RST;
      target      <= TARGET_RST;
      hyst        <= HYST_RST;
      step        <= STEP_RST;
      hold_cycles <= HOLD_RST;
    end else begin
      if (wr_ctrl)   enable      <= set_data[0];
      if (wr_target) target      <= set_data[16:0];
      if (wr_hyst)   hyst        <= set_data[15:0];
      if (wr_step)   step        <= set_data[15:0];
      if (wr_hold)   hold_cycles <= set_data[15:0];
    end
  end

  agc_mag_accum #(.WIN_LOG2(WIN_LOG2)) u_accum (
    .ce_clk      (ce_clk),
    .ce_rst      (ce_rst),
    .clear       (acc_clear),
    .count_en    (acc_en),
    .sample_fire (mon_tvalid & mon_tready),
    .sample      (mon_tdata),
    .avg         (avg),
    .win_done    (win_done)
  );

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Disable and init_gain writes pre-empt whatever the loop is doing.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else if (wr_init) begin
      state_next = MEASURE;
    end else begin
      unique case (state)
        IDLE:    state_next = MEASURE;
        MEASURE: if (win_done) state_next = DECIDE;
        DECIDE:  state_next = (hold_cycles == 16'd0) ? MEASURE : HOLD;
        HOLD:    if (hold_cnt <= 16'd1) state_next = MEASURE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    acc_en    = 1'b0;
    acc_clear = 1'b1;
    decide_en = 1'b0;
    if (state == MEASURE) begin
      acc_en    = 1'b1;
      acc_clear = wr_init;
    end
    if (state == DECIDE) decide_en = enable & ~wr_init;
  end

  // Snapshot of hold taken at DECIDE so a mid-hold write cannot stretch the current hold.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      hold_cnt <= '0;
    end else if (state == DECIDE) begin
      hold_cnt <= hold_cycles;
    end else if (state == HOLD && hold_cnt != 16'd0) begin
      hold_cnt <= hold_cnt - 16'd1;
    end
  end

  logic [17:0]        band_hi;
  logic [16:0]        band_lo;
  logic               too_high, too_low;
  logic [ARITH_W-1:0] gain_ext, step_ext, gain_sum;
  logic [GAIN_W-1:0]  gain_dn, gain_up;

  assign band_hi  = {1'b0, target} + {2'b00, hyst};
  assign band_lo  = (target > {1'b0, hyst}) ? target - {1'b0, hyst} : '0;
  assign too_high = {1'b0, avg} > band_hi;
  assign too_low  = avg < band_lo;

  assign gain_ext = ARITH_W'(gain);
  assign step_ext = ARITH_W'(step);
  assign gain_sum = gain_ext + step_ext;
  assign gain_dn  = (step_ext > gain_ext) ? '0 : GAIN_W'(gain_ext - step_ext);
  assign gain_up  = (gain_sum > GAIN_MAX) ? GAIN_W'(GAIN_MAX) : GAIN_W'(gain_sum);

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      gain       <= GAIN_W'(GAIN_UNITY);
      gain_valid <= 1'b0;
      locked     <= 1'b0;
      avg_mag    <= '0;
    end else begin
      gain_valid <= 1'b0;
      if (wr_init) begin
        gain       <= GAIN_W'(set_data[15:0]);
        gain_valid <= 1'b1;
        locked     <= 1'b0;
      end else if (decide_en) begin
        avg_mag <= avg;
        if (too_high) begin
          gain       <= gain_dn;
          gain_valid <= 1'b1;
          locked     <= 1'b0;
        end else if (too_low) begin
          gain       <= gain_up;
          gain_valid <= 1'b1;
          locked     <= 1'b0;
        end else begin
          locked <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Self-checking bench for agc_gain_ctrl with a window-level reference model.
module tb_agc_gain_ctrl;

  localparam int WL  = 2;
  localparam int NW  = 4;
  localparam int SRB = 130;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] mon_tdata = '0;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic [15:0] gain;
  logic        gain_valid;
  logic        locked;
  logic [16:0] avg_mag;

  int checks = 0;
  int failures = 0;

  int m_target, m_hyst, m_step, m_hold, m_gain, m_locked, m_avg, m_gv;
  logic [15:0] win_i [NW];
  logic [15:0] win_q [NW];

  always #5 ce_clk = ~ce_clk;

  agc_gain_ctrl #(.WIN_LOG2(WL), .GAIN_W(16), .SR_BASE(SRB)) dut (
    .ce_clk     (ce_clk),
    .ce_rst     (ce_rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .mon_tdata  (mon_tdata),
    .mon_tvalid (mon_tvalid),
    .mon_tready (mon_tready),
    .gain       (gain),
    .gain_valid (gain_valid),
    .locked     (locked),
    .avg_mag    (avg_mag)
  );

  function automatic int abs16(input logic [15:0] v);
    int s;
    s = $signed(v);
    return (s < 0) ? -s : s;
  endfunction

  function automatic void model_reset();
    m_target = 'h4000; m_hyst = 'h400; m_step = 'h100; m_hold = 16;
    m_gain = 'h1000; m_locked = 0; m_avg = 0; m_gv = 0;
  endfunction

  // Mean of the window, then the target/hysteresis rules with saturation.
  function automatic void model_decide();
    int sum, lo, hi;
    sum = 0;
    for (int k = 0; k < NW; k++) sum += abs16(win_i[k]) + abs16(win_q[k]);
    m_avg = sum / NW;
    hi = m_target + m_hyst;
    lo = m_target - m_hyst;
    if (lo < 0) lo = 0;
    if (m_avg > hi) begin
      m_gain = m_gain - m_step;
      if (m_gain < 0) m_gain = 0;
      m_gv = 1; m_locked = 0;
    end else if (m_avg < lo) begin
      m_gain = m_gain + m_step;
      if (m_gain > 65535) m_gain = 65535;
      m_gv = 1; m_locked = 0;
    end else begin
      m_gv = 0; m_locked = 1;
    end
  endfunction

  task automatic write_reg(input int off, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = 8'(SRB + off);
    set_data = d;
    @(negedge ce_clk);
    set_stb  = 1'b0;
    set_data = $urandom;
  endtask

  task automatic set_init(input logic [15:0] g);
    write_reg(5, {$urandom_range(0, 65535), g} & 32'hFFFF_FFFF);
    m_gain = g; m_locked = 0; m_gv = 1;
  endtask

  task automatic enable_block();
    write_reg(0, 32'h1);
    @(negedge ce_clk);
  endtask

  task automatic fill_win(input logic [15:0] i, input logic [15:0] q);
    for (int k = 0; k < NW; k++) begin
      win_i[k] = i;
      win_q[k] = q;
    end
  endtask

  // Drives n handshakes from the window arrays with random non-handshake gaps,
  // then returns one full cycle after the last handshake.
  task automatic send_samples(input int n);
    int k;
    k = 0;
    while (k < n) begin
      if ($urandom_range(0, 3) == 0) begin
        mon_tvalid = 1'($urandom_range(0, 1));
        mon_tready = ~mon_tvalid;
        mon_tdata  = $urandom;
      end else begin
        mon_tdata  = {win_i[k], win_q[k]};
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        k++;
      end
      @(negedge ce_clk);
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    @(negedge ce_clk);
  endtask

  task automatic dead_cycles(input int n, input bit junk);
    for (int c = 0; c < n; c++) begin
      mon_tvalid = junk;
      mon_tready = junk;
      mon_tdata  = junk ? 32'h7FFF_7FFF : 32'h0;
      @(negedge ce_clk);
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    ce_rst = 1'b1;
    repeat (3) @(negedge ce_clk);
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'h1000, 1'b0, 1'b0, 17'h0}) begin
      failures++;
      $display("FAIL reset_hold: got gain=%h gv=%b lk=%b avg=%h want gain=1000 gv=0 lk=0 avg=0",
               gain, gain_valid, locked, avg_mag);
    end
    ce_rst = 1'b0;
    repeat (2) @(negedge ce_clk);
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL reset_release: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    write_reg(4, 32'd4);
    m_hold = 4;
  endtask

  task automatic test_lock_in_band();
    fill_win(16'h2000, 16'h2000);
    enable_block();
    send_samples(NW);
    model_decide();
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL lock_in_band: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    dead_cycles(m_hold, 1'b0);
  endtask

  task automatic test_step_down_hold();
    fill_win(16'h4000, 16'h4000);
    send_samples(NW);
    model_decide();
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL step_down: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    @(negedge ce_clk);
    checks++;
    if (gain_valid !== 1'b0) begin
      failures++;
      $display("FAIL gain_valid_width: got gv=%b want gv=0", gain_valid);
    end
    dead_cycles(m_hold - 1, 1'b1);
    fill_win(16'h2000, 16'h2000);
    send_samples(NW);
    model_decide();
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL hold_ignores_samples: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    dead_cycles(m_hold, 1'b1);
  endtask

  task automatic test_sat_high();
    write_reg(3, 32'h8000);
    m_step = 'h8000;
    set_init(16'hC000);
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL init_load: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    fill_win(16'h0100, 16'h0100);
    for (int w = 0; w < 2; w++) begin
      send_samples(NW);
      model_decide();
      checks++;
      if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
        failures++;
        $display("FAIL sat_high[%0d]: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
                 w, gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
      end
      dead_cycles(m_hold, 1'b1);
    end
  endtask

  task automatic test_sat_low();
    fill_win(16'h8000, 16'h8000);
    for (int w = 0; w < 3; w++) begin
      if (w == 1) set_init(16'h0080);
      send_samples(NW);
      model_decide();
      checks++;
      if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
        failures++;
        $display("FAIL sat_low[%0d]: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
                 w, gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
      end
      dead_cycles(m_hold, 1'b1);
    end
  endtask

  task automatic test_enable_abort();
    write_reg(3, 32'h0100);
    m_step = 'h100;
    set_init(16'h1000);
    fill_win(16'h7FFF, 16'h7FFF);
    send_samples(2);
    write_reg(0, 32'h0);
    repeat (2) @(negedge ce_clk);
    checks++;
    if ({gain, gain_valid, locked} !== {16'(m_gain), 1'b0, 1'(m_locked)}) begin
      failures++;
      $display("FAIL disable_no_decision: got gain=%h gv=%b lk=%b want gain=%h gv=0 lk=%0d",
               gain, gain_valid, locked, m_gain, m_locked);
    end
    enable_block();
    fill_win(16'h2000, 16'h2000);
    send_samples(NW);
    model_decide();
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL fresh_window: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    dead_cycles(m_hold, 1'b1);
  endtask

  task automatic test_init_in_decide();
    fill_win(16'h4000, 16'h4000);
    send_samples(NW - 1);
    mon_tdata  = {win_i[NW-1], win_q[NW-1]};
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    @(negedge ce_clk);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    set_init(16'h2000);
    checks++;
    if ({gain, gain_valid, locked} !== {16'(m_gain), 1'(m_gv), 1'(m_locked)}) begin
      failures++;
      $display("FAIL init_wins_decide: got gain=%h gv=%b lk=%b want gain=%h gv=%0d lk=%0d",
               gain, gain_valid, locked, m_gain, m_gv, m_locked);
    end
    fill_win(16'h2000, 16'h2000);
    send_samples(NW);
    model_decide();
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL after_init_window: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
    dead_cycles(m_hold, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] raw;
    for (int r = 0; r < 8; r++) begin
      m_target = $urandom_range('h4000, 'hC000);
      raw = ($urandom & 32'hFFFE_0000) | 32'(m_target);
      write_reg(1, raw);
      m_hyst = $urandom_range(0, 'h2000);
      write_reg(2, ($urandom & 32'hFFFF_0000) | 32'(m_hyst));
      m_step = $urandom_range(0, 'hFFFF);
      write_reg(3, 32'(m_step));
      m_hold = $urandom_range(0, 5);
      write_reg(4, 32'(m_hold));
      for (int k = 0; k < NW; k++) begin
        win_i[k] = 16'($urandom);
        win_q[k] = 16'($urandom);
      end
      send_samples(NW);
      model_decide();
      checks++;
      if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
        failures++;
        $display("FAIL random[%0d]: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
                 r, gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
      end
      dead_cycles(m_hold, 1'b1);
    end
  endtask

  task automatic test_reset_mid_measure();
    set_init(16'h3456);
    fill_win(16'h1234, 16'hF00D);
    send_samples(2);
    ce_rst = 1'b1;
    #1;
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'h1000, 1'b0, 1'b0, 17'h0}) begin
      failures++;
      $display("FAIL async_reset: got gain=%h gv=%b lk=%b avg=%h want gain=1000 gv=0 lk=0 avg=0",
               gain, gain_valid, locked, avg_mag);
    end
    @(negedge ce_clk);
    ce_rst = 1'b0;
    model_reset();
    @(negedge ce_clk);
    fill_win(16'h4000, 16'h4000);
    send_samples(NW);
    @(negedge ce_clk);
    checks++;
    if ({gain, gain_valid, locked, avg_mag} !== {16'(m_gain), 1'(m_gv), 1'(m_locked), 17'(m_avg)}) begin
      failures++;
      $display("FAIL disabled_after_reset: got gain=%h gv=%b lk=%b avg=%h want gain=%h gv=%0d lk=%0d avg=%h",
               gain, gain_valid, locked, avg_mag, m_gain, m_gv, m_locked, m_avg);
    end
  endtask

  initial begin
    test_reset();
    test_lock_in_band();
    test_step_down_hold();
    test_sat_high();
    test_sat_low();
    test_enable_abort();
    test_init_in_decide();
    test_random();
    test_reset_mid_measure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
